// File: rtl/iscb_pkg.sv
// ---------------------------------------------------------------------------
// iscb_pkg -- shared constants and helpers for the iscb stochastic blocks.
//   LFSR_W            : width of the decorrelation LFSR (8 bits)
//   LFSR_TAPS         : tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   LFSR_SEED_DEFAULT : default nonzero seed
//   lfsr_next()       : one Fibonacci step, shift left, feedback into bit 0
//   seed_fix()        : maps an all-zero seed to 8'h01 (LFSR lock-up guard)
// ---------------------------------------------------------------------------
package iscb_pkg;

    localparam int             LFSR_W            = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS      = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 8'hA5;

    // Alternating 0101... pattern (bit i = i[0]); the shuffle buffer resets to
    // the low DEPTH bits of this, which is a bipolar-zero stream.
    localparam logic [15:0]    BUF_ALT_PATTERN   = 16'hAAAA;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/iscbsquare_if.sv
// ---------------------------------------------------------------------------
// iscbsquare_if -- stream bus of the stochastic squarer.
//   in_vld  : current in bit is a valid stream bit      (master -> slave)
//   in      : input stochastic bit                      (master -> slave)
//   out_vld : out carries a valid squared-stream bit    (slave -> master)
//   out     : output stochastic bit                     (slave -> master)
// ---------------------------------------------------------------------------
interface iscbsquare_if;

    logic in_vld;
    logic in;
    logic out_vld;
    logic out;

    modport master (output in_vld, output in, input out_vld, input out);
    modport slave  (input in_vld, input in, output out_vld, output out);

endinterface

// File: rtl/iscb_lfsr.sv
// ---------------------------------------------------------------------------
// iscb_lfsr -- 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing only when
// en is high. Reusable by any iscb block that needs a pseudo-random index.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads seed
//   en    : advance one step this cycle
//   seed  : reset value, must be nonzero (callers pass it through seed_fix)
//   state : current LFSR value (registered)
// ---------------------------------------------------------------------------
module iscb_lfsr
    import iscb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    assign state_d = en ? lfsr_next(state_q) : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/iscbsquare.sv
// ---------------------------------------------------------------------------
// iscbsquare -- stochastic squarer. Each valid input bit is multiplied by a
// bit drawn from a DEPTH-entry shuffle buffer (an older sample of the same
// stream), then written into that same slot. The slot index comes from the
// low bits of an LFSR that steps once per accepted bit, so gaps in in_vld
// only delay the output sequence and never change it.
//   Parameters: DEPTH (2..16, power of 2), BIPOLAR (1 = XNOR, 0 = AND),
//               SEED (LFSR seed, zero is replaced by 8'h01)
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : iscbsquare_if.slave (in_vld, in -> out_vld, out)
// ---------------------------------------------------------------------------
module iscbsquare
    import iscb_pkg::*;
#(
    parameter int                DEPTH   = 4,
    parameter int                BIPOLAR = 1,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_SEED_DEFAULT
)
(
    input  logic         clk,
    input  logic         rst_n,
    iscbsquare_if.slave  bus
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);
    localparam logic [DEPTH-1:0]  BUF_RST  = BUF_ALT_PATTERN[DEPTH-1:0];

    logic [LFSR_W-1:0] lfsr_state;
    logic [IDX_W-1:0]  idx;
    logic              unused_lfsr_bits;

    logic [DEPTH-1:0]  buf_q;
    logic [DEPTH-1:0]  buf_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              out_q;
    logic              out_d;
    logic              out_vld_q;
    logic              out_vld_d;

    logic              d;
    logic              p;
    logic              warm;

    iscb_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.in_vld),
        .seed  (SEED_EFF),
        .state (lfsr_state)
    );

    // Index uses the LFSR value before this cycle's step.
    assign idx              = lfsr_state[IDX_W-1:0];
    assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:IDX_W];

    // Read-before-write: d is the old slot content, the slot takes in.
    assign d = buf_q[idx];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign buf_d[gi] = (bus.in_vld && (idx == IDX_W'(gi))) ? bus.in : buf_q[gi];
        end
    endgenerate

    assign p = (BIPOLAR != 0) ? ~(bus.in ^ d) : (bus.in & d);

    // warm counts the current input, so the DEPTH-th accepted bit is the
    // first one flagged valid at the output.
    assign warm      = (cnt_q >= CNT_W'(DEPTH - 1));
    assign cnt_d     = (bus.in_vld && (cnt_q != CNT_W'(DEPTH))) ? cnt_q + 1'b1 : cnt_q;
    assign out_d     = bus.in_vld ? p : out_q;
    assign out_vld_d = bus.in_vld & warm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= BUF_RST;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_vld = out_vld_q;

endmodule
